// File: rtl/bsg_comm_link_core_arb.sv
// Round-robin packet arbiter feeding the comm link core input; a granted requester owns the link until its last word.
// Optional per-requester packet counters are enabled by defining BSG_COMM_LINK_CORE_ARB_STATS_EN.
module bsg_comm_link_core_arb #(
  parameter int num_req_p   = 4,
  parameter int width_p     = 32,
  parameter int cnt_width_p = 16
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             calib_done_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p*width_p-1:0]     req_data_i,
  input  logic [num_req_p-1:0]             req_last_i,
  output logic [num_req_p-1:0]             req_yumi_o,
  output logic                             core_v_o,
  output logic [width_p-1:0]               core_data_o,
  input  logic                             core_ready_i,
  output logic [num_req_p-1:0]             grant_o,
  output logic [num_req_p*cnt_width_p-1:0] pkt_cnt_o
);

  localparam int lg_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]           state_r;
  logic [lg_w-1:0]      owner_r;
  logic [lg_w-1:0]      ptr_r;
  logic [lg_w-1:0]      win;
  logic [lg_w-1:0]      idx;
  logic [lg_w-1:0]      sel;
  logic [lg_w-1:0]      nxt_ptr;
  logic                 found;
  logic                 cur_v;
  logic                 owns;
  logic                 yumi_any;
  logic                 done;
  logic [num_req_p-1:0] sel_onehot;

  // Scan upward from the pointer with wrap; first valid requester wins
  always_comb begin
    win   = ptr_r;
    idx   = ptr_r;
    found = 1'b0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = lg_w'((int'(ptr_r) + k) % num_req_p);
      if (!found && req_v_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // A locked owner is forwarded regardless of calibration so its packet can finish
  always_comb begin
    sel   = owner_r;
    cur_v = 1'b0;
    if (state_r == IDLE) begin
      sel   = win;
      cur_v = calib_done_i & found;
    end else begin
      cur_v = req_v_i[owner_r];
    end
    if (!reset_n_i) cur_v = 1'b0;
  end

  assign owns       = reset_n_i & ((state_r == LOCKED) | cur_v);
  assign sel_onehot = {{(num_req_p-1){1'b0}}, 1'b1} << sel;
  assign yumi_any   = cur_v & core_ready_i;
  assign done       = yumi_any & req_last_i[sel];
  assign nxt_ptr    = (sel == lg_w'(num_req_p-1)) ? '0 : sel + lg_w'(1);

  assign core_v_o    = cur_v;
  assign core_data_o = req_data_i[int'(sel)*width_p +: width_p];
  assign grant_o     = owns ? sel_onehot : '0;
  assign req_yumi_o  = yumi_any ? sel_onehot : '0;

  // Lock on any presented word that does not finish the packet, even under backpressure
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      owner_r <= '0;
      ptr_r   <= '0;
    end else begin
      if (state_r == IDLE) begin
        if (cur_v) begin
          owner_r <= sel;
          if (!done) state_r <= LOCKED;
        end
      end else if (done) begin
        state_r <= IDLE;
      end
      if (done) ptr_r <= nxt_ptr;
    end
  end

`ifdef BSG_COMM_LINK_CORE_ARB_STATS_EN
  logic [cnt_width_p-1:0] cnt_r [num_req_p];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_req_p; i++) begin
      if (!reset_n_i) begin
        cnt_r[i] <= '0;
      end else if (done && (sel == lg_w'(i))) begin
        cnt_r[i] <= cnt_r[i] + cnt_width_p'(1);
      end
    end
  end

  for (genvar g = 0; g < num_req_p; g++) begin : g_cnt
    assign pkt_cnt_o[g*cnt_width_p +: cnt_width_p] = cnt_r[g];
  end
`else
  assign pkt_cnt_o = '0;
`endif

endmodule
